// File: rtl/image_op_sequencer.sv
// Frame-level sequencer: takes one host request, starts the pixel datapath, checks a full frame.
// Define WATCHDOG_EN to add a progress watchdog on WAIT_VSYNC/RUN; without it those states wait indefinitely.
//   state      | meaning
//   IDLE       | ready for a host request
//   START      | one-cycle datapath start pulse
//   WAIT_VSYNC | waiting for the end of VSYNC
//   RUN        | counting lines until done
//   DRAIN      | post-frame hold, then frame_done
//   ERROR      | one cycle after a protocol or timeout error
module image_op_sequencer #(
   parameter int HEIGHT       = 512,
   parameter int TIMEOUT      = 20000,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [7:0]  req_value,
   output logic        dp_start,
   output logic [2:0]  dp_op,
   output logic [7:0]  dp_value,
   input  logic        dp_vsync,
   input  logic        dp_hsync,
   input  logic        dp_done,
   output logic        busy,
   output logic [9:0]  line_cnt,
   output logic        frame_done,
   output logic [15:0] frame_cnt,
   output logic        err,
   input  logic        err_clr
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT_VSYNC, S_RUN, S_DRAIN, S_ERROR
   } state_t;

   localparam logic [9:0] LINES      = 10'(HEIGHT);
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_t     state;
   logic       vsync_q, vsync_p, hsync_q, hsync_p, done_q;
   logic       vsync_fall, hsync_rise, wd_expired;
   logic [3:0] drain_cnt;

`ifdef WATCHDOG_EN
   logic [20:0] wd;
   assign wd_expired = (wd + 21'd1) >= 21'(TIMEOUT);
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         vsync_q <= 1'b0;
         vsync_p <= 1'b0;
         hsync_q <= 1'b0;
         hsync_p <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         vsync_q <= dp_vsync;
         vsync_p <= vsync_q;
         hsync_q <= dp_hsync;
         hsync_p <= hsync_q;
         done_q  <= dp_done;
      end
   end

   assign vsync_fall = ~vsync_q & vsync_p;
   assign hsync_rise = hsync_q & ~hsync_p;

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= S_IDLE;
         dp_start   <= 1'b0;
         dp_op      <= 3'd0;
         dp_value   <= 8'd0;
         line_cnt   <= 10'd0;
         frame_done <= 1'b0;
         frame_cnt  <= 16'd0;
         err        <= 1'b0;
         drain_cnt  <= 4'd0;
`ifdef WATCHDOG_EN
         wd         <= 21'd0;
`endif
      end else begin
         dp_start   <= 1'b0;
         frame_done <= 1'b0;
         // a new error later in this block overrides the clear
         if (err_clr) err <= 1'b0;
`ifdef WATCHDOG_EN
         wd <= 21'd0;
`endif
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_op <= 3'd4) begin
                     dp_op    <= req_op;
                     dp_value <= req_value;
                     line_cnt <= 10'd0;
                     dp_start <= 1'b1;
                     state    <= S_START;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_START: state <= S_WAIT_VSYNC;
            S_WAIT_VSYNC: begin
               if (done_q) begin
                  state <= S_ERROR;
                  err   <= 1'b1;
               end else if (vsync_fall) begin
                  state <= S_RUN;
               end else if (wd_expired) begin
                  state <= S_ERROR;
                  err   <= 1'b1;
               end
`ifdef WATCHDOG_EN
               else wd <= wd + 21'd1;
`endif
            end
            S_RUN: begin
               if (done_q) begin
                  if (line_cnt == LINES) begin
                     state     <= S_DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                  end else begin
                     state <= S_ERROR;
                     err   <= 1'b1;
                  end
               end else if (hsync_rise) begin
                  if (line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;
               end else if (wd_expired) begin
                  state <= S_ERROR;
                  err   <= 1'b1;
               end
`ifdef WATCHDOG_EN
               else wd <= wd + 21'd1;
`endif
            end
            S_DRAIN: begin
               // frame_done shows in the last DRAIN cycle, IDLE follows
               if (drain_cnt == 4'd0) begin
                  state <= S_IDLE;
               end else begin
                  drain_cnt <= drain_cnt - 4'd1;
                  if (drain_cnt == 4'd1) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 16'd1;
                  end
               end
            end
            S_ERROR: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_image_op_sequencer.sv
// Self-checking bench for image_op_sequencer: random frames against a frame-level reference model.
module tb_image_op_sequencer;
   localparam int HEIGHT  = 512;
   localparam int TIMEOUT = 1000;
   localparam int DRAIN   = 4;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [7:0]  req_value = 8'd0;
   logic        dp_start;
   logic [2:0]  dp_op;
   logic [7:0]  dp_value;
   logic        dp_vsync = 1'b0, dp_hsync = 1'b0, dp_done = 1'b0;
   logic        busy;
   logic [9:0]  line_cnt;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic        err;
   logic        err_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   // reference model: what the host should observe at frame granularity
   int         exp_frames = 0;
   bit         exp_err = 1'b0;
   logic [2:0] exp_op = 3'd0;
   logic [7:0] exp_val = 8'd0;

   always #5 HCLK = ~HCLK;

   image_op_sequencer #(.HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_value(req_value),
      .dp_start(dp_start), .dp_op(dp_op), .dp_value(dp_value),
      .dp_vsync(dp_vsync), .dp_hsync(dp_hsync), .dp_done(dp_done),
      .busy(busy), .line_cnt(line_cnt), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .err(err), .err_clr(err_clr)
   );

   task automatic drive_lines(input int n);
      for (int i = 0; i < n; i++) begin
         dp_hsync = 1'b1;
         repeat ($urandom_range(1, 2)) @(negedge HCLK);
         dp_hsync = 1'b0;
         repeat ($urandom_range(1, 2)) @(negedge HCLK);
      end
   endtask

   task automatic start_frame(input logic [2:0] op, input logic [7:0] val);
      req_valid = 1'b1; req_op = op; req_value = val;
      @(negedge HCLK);
      req_valid = 1'b0;
      exp_op = op; exp_val = val;
      checks++; if (dp_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b want 1", dp_start); end
      checks++; if (dp_op !== exp_op) begin errors++; $display("FAIL start_op: got %0d want %0d", dp_op, exp_op); end
      checks++; if (dp_value !== exp_val) begin errors++; $display("FAIL start_value: got %0d want %0d", dp_value, exp_val); end
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL start_busy: busy %b ready %b want 1 0", busy, req_ready); end
      checks++; if (line_cnt !== 10'd0) begin errors++; $display("FAIL start_line_cnt: got %0d want 0", line_cnt); end
      @(negedge HCLK);
      checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b want 0", dp_start); end
      dp_vsync = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge HCLK);
      dp_vsync = 1'b0;
      repeat (2) @(negedge HCLK);
   endtask

   task automatic finish_frame(input int nlines);
      int  lines_exp;
      bit  ok;
      int  cnt;
      logic err_at_error;
      lines_exp = (nlines > 1023) ? 1023 : nlines;
      ok = (lines_exp == HEIGHT);
      checks++; if (line_cnt !== 10'(lines_exp)) begin errors++; $display("FAIL line_count: got %0d want %0d", line_cnt, lines_exp); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b want 1", busy); end
      dp_done = 1'b1;
      @(negedge HCLK);
      dp_done = 1'b0;
      cnt = 1;
      err_at_error = 1'b0;
      while (busy === 1'b1 && frame_done !== 1'b1 && cnt < 40) begin
         @(negedge HCLK);
         cnt++;
         if (cnt == 2) err_at_error = err;
      end
      if (ok) begin
         exp_frames = (exp_frames + 1) % 65536;
         checks++; if (frame_done !== 1'b1 || cnt != DRAIN + 2) begin errors++; $display("FAIL frame_done_timing: done %b after %0d cycles want 1 after %0d", frame_done, cnt, DRAIN + 2); end
         checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
         checks++; if (dp_op !== exp_op || dp_value !== exp_val) begin errors++; $display("FAIL op_stable: got %0d/%0d want %0d/%0d", dp_op, dp_value, exp_op, exp_val); end
         checks++; if (err !== exp_err) begin errors++; $display("FAIL ok_err: got %b want %b", err, exp_err); end
         @(negedge HCLK);
         checks++; if (frame_done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL after_frame: done %b ready %b busy %b want 0 1 0", frame_done, req_ready, busy); end
      end else begin
         exp_err = 1'b1;
         checks++; if (frame_done !== 1'b0 || cnt != 3) begin errors++; $display("FAIL error_exit: done %b idle after %0d want 0 after 3", frame_done, cnt); end
         checks++; if (err_at_error !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL error_flag: in ERROR %b after %b want 1 1", err_at_error, err); end
         checks++; if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL error_frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
      end
   endtask

   task automatic run_frame(input logic [2:0] op, input logic [7:0] val, input int nlines);
      start_frame(op, val);
      drive_lines(nlines);
      finish_frame(nlines);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge HCLK);
      err_clr = 1'b0;
      exp_err = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err); end
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      repeat (2) @(negedge HCLK);
      checks++; if (dp_start !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: start %b done %b err %b want 0 0 0", dp_start, frame_done, err); end
      checks++; if (dp_op !== 3'd0 || dp_value !== 8'd0) begin errors++; $display("FAIL reset_op: got %0d/%0d want 0/0", dp_op, dp_value); end
      checks++; if (line_cnt !== 10'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: lines %0d frames %0d want 0 0", line_cnt, frame_cnt); end
      HRESET = 1'b0;
      @(negedge HCLK);
      checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: ready %b busy %b want 1 0", req_ready, busy); end
   endtask

   task automatic test_basic_frame();
      run_frame(3'd1, 8'd100, HEIGHT);
   endtask

   task automatic test_illegal_op();
      bit rose;
      req_valid = 1'b1; req_op = 3'($urandom_range(5, 7)); req_value = 8'($urandom);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready_before: got %b want 1", req_ready); end
      @(negedge HCLK);
      req_valid = 1'b0;
      exp_err = 1'b1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err); end
      checks++; if (dp_op !== exp_op || dp_value !== exp_val || dp_start !== 1'b0) begin errors++; $display("FAIL illegal_op_kept: got %0d/%0d start %b want %0d/%0d 0", dp_op, dp_value, dp_start, exp_op, exp_val); end
      rose = (busy !== 1'b0) || (req_ready !== 1'b1);
      repeat (3) begin
         @(negedge HCLK);
         if (busy !== 1'b0 || req_ready !== 1'b1) rose = 1'b1;
      end
      checks++; if (rose) begin errors++; $display("FAIL illegal_busy: busy rose %b want 0", rose); end
      clear_err();
      req_valid = 1'b1; req_op = 3'd7; err_clr = 1'b1;
      @(negedge HCLK);
      req_valid = 1'b0; err_clr = 1'b0;
      exp_err = 1'b1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", err); end
      clear_err();
   endtask

   task automatic test_random_frames();
      repeat (3) run_frame(3'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), HEIGHT);
   endtask

   task automatic test_bad_line_count();
      run_frame(3'($urandom_range(0, 4)), 8'($urandom), HEIGHT - 1);
      clear_err();
      run_frame(3'($urandom_range(0, 4)), 8'($urandom), HEIGHT + 1);
      clear_err();
      run_frame(3'($urandom_range(0, 4)), 8'($urandom), 1030);
      clear_err();
   endtask

   task automatic test_watchdog();
      int cnt;
      start_frame(3'd0, 8'($urandom));
      drive_lines(5);
      dp_hsync = 1'b1;
      @(negedge HCLK);
      dp_hsync = 1'b0;
      cnt = 1;
      while (err !== 1'b1 && cnt < TIMEOUT + 50) begin
         @(negedge HCLK);
         cnt++;
      end
      checks++; if (line_cnt !== 10'd6) begin errors++; $display("FAIL stall_lines: got %0d want 6", line_cnt); end
`ifdef WATCHDOG_EN
      checks++; if (err !== 1'b1 || cnt != TIMEOUT + 2) begin errors++; $display("FAIL watchdog_timing: err %b after %0d want 1 after %0d", err, cnt, TIMEOUT + 2); end
      @(negedge HCLK);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL watchdog_idle: busy %b want 0", busy); end
      exp_err = 1'b1;
`else
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_watchdog_wait: err %b busy %b want 0 1", err, busy); end
      finish_frame(6);
`endif
      clear_err();
   endtask

   task automatic test_wrap();
      force dut.frame_cnt = 16'hFFFF;
      @(negedge HCLK);
      release dut.frame_cnt;
      exp_frames = 65535;
      run_frame(3'd4, 8'($urandom), HEIGHT);
   endtask

   task automatic test_reset_midframe();
      req_valid = 1'b1; req_op = 3'd5;
      @(negedge HCLK);
      req_valid = 1'b0;
      exp_err = 1'b1;
      start_frame(3'($urandom_range(1, 4)), 8'($urandom_range(1, 255)));
      drive_lines(100);
      checks++; if (line_cnt !== 10'd100 || err !== 1'b1) begin errors++; $display("FAIL pre_reset: lines %0d err %b want 100 1", line_cnt, err); end
      #2 HRESET = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || line_cnt !== 10'd0) begin errors++; $display("FAIL async_reset_state: busy %b ready %b lines %0d want 0 1 0", busy, req_ready, line_cnt); end
      checks++; if (dp_op !== 3'd0 || dp_value !== 8'd0 || err !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_regs: op %0d val %0d err %b frames %0d want 0 0 0 0", dp_op, dp_value, err, frame_cnt); end
      @(negedge HCLK);
      HRESET = 1'b0;
      exp_frames = 0; exp_err = 1'b0; exp_op = 3'd0; exp_val = 8'd0;
      @(negedge HCLK);
      run_frame(3'($urandom_range(0, 4)), 8'($urandom), HEIGHT);
   endtask

   task automatic test_back_to_back();
      run_frame(3'($urandom_range(0, 4)), 8'($urandom), HEIGHT);
      run_frame(3'($urandom_range(0, 4)), 8'($urandom), HEIGHT);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_illegal_op();
      test_random_frames();
      test_bad_line_count();
      test_watchdog();
      test_wrap();
      test_reset_midframe();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule
